// File: rtl/manchester_tx.sv
// manchester_tx
//   Takes 16-bit words from the SPI slave receive stage and sends each one as
//   a Manchester-coded frame on a single wire. The frame is SYNC_BITS '1' bits,
//   then the data MSB first, then an optional parity bit, then a one-bit-time
//   low stop guard. A one-deep holding register takes a word that arrives while
//   a frame is still being sent. A word that arrives while that register is
//   already full is dropped and flags overrun.
//   Encoding follows IEEE 802.3: '1' is sent low then high, '0' is sent high
//   then low, and the idle line is low.
//
// Build option: define PARITY_EN to send an even-parity bit after the data.
//
// Ports
//   clk_in   system clock
//   rst      synchronous reset, active low
//   rx_data  word from the SPI slave
//   rx_flag  level from the SPI slave; each rising edge marks a new word
//   man_out  registered Manchester line
//   tx_busy  high while a frame is being sent
//   tx_done  one-cycle pulse at the end of each frame
//   overrun  sticky drop flag; only reset clears it
module manchester_tx #(
   parameter int DATA_W    = 16,
   parameter int CLK_DIV   = 4,
   parameter int SYNC_BITS = 3
) (
   input  logic              clk_in,
   input  logic              rst,
   input  logic [DATA_W-1:0] rx_data,
   input  logic              rx_flag,
   output logic              man_out,
   output logic              tx_busy,
   output logic              tx_done,
   output logic              overrun
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BW = $clog2(DATA_W + SYNC_BITS);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_SYNC = 3'd1;
   localparam logic [2:0] S_DATA = 3'd2;
`ifdef PARITY_EN
   localparam logic [2:0] S_PAR  = 3'd3;
`endif
   localparam logic [2:0] S_STOP = 3'd4;

   logic [2:0]        state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              half_q, half_d;
   logic [BW-1:0]     bit_q, bit_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [DATA_W-1:0] hold_q, hold_d;
   logic              hold_vld_q, hold_vld_d;
   logic              flag_q;
   logic              man_q, man_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              ovr_q, ovr_d;
`ifdef PARITY_EN
   logic              par_q, par_d;
`endif

   logic trig, drain, half_end, bit_end;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      half_d     = half_q;
      bit_d      = bit_q;
      shift_d    = shift_q;
      hold_d     = hold_q;
      hold_vld_d = hold_vld_q;
      ovr_d      = ovr_q;
      man_d      = 1'b0;
      done_d     = 1'b0;
`ifdef PARITY_EN
      par_d      = par_q;
`endif

      trig     = rx_flag & ~flag_q;
      drain    = (state_q == S_IDLE) && hold_vld_q;
      half_end = (cnt_q == CW'(CLK_DIV - 1));
      bit_end  = half_end && half_q;

      // Half-bit timing runs whenever a frame is in progress.
      if (state_q != S_IDLE) begin
         cnt_d = half_end ? '0 : cnt_q + 1'b1;
         if (half_end) half_d = ~half_q;
      end

      // man_d encodes the half-bit of the current state. The line register
      // therefore trails the state by one cycle. That is where the second
      // cycle of trigger-to-line latency comes from.
      case (state_q)
         S_IDLE: begin
            if (hold_vld_q) begin
               shift_d = hold_q;
`ifdef PARITY_EN
               par_d   = ^hold_q;
`endif
               cnt_d   = '0;
               half_d  = 1'b0;
               bit_d   = '0;
               state_d = S_SYNC;
            end
         end
         S_SYNC: begin
            man_d = half_q;
            if (bit_end) begin
               if (bit_q == BW'(SYNC_BITS - 1)) begin
                  bit_d   = '0;
                  state_d = S_DATA;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
         end
         S_DATA: begin
            man_d = half_q ? shift_q[DATA_W-1] : ~shift_q[DATA_W-1];
            if (bit_end) begin
               shift_d = {shift_q[DATA_W-2:0], 1'b0};
               if (bit_q == BW'(DATA_W - 1)) begin
                  bit_d   = '0;
`ifdef PARITY_EN
                  state_d = S_PAR;
`else
                  state_d = S_STOP;
`endif
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
         end
`ifdef PARITY_EN
         S_PAR: begin
            man_d = half_q ? par_q : ~par_q;
            if (bit_end) state_d = S_STOP;
         end
`endif
         S_STOP: begin
            if (bit_end) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Holding register. If the register drains in this cycle, it can take
      // a new word in the same cycle.
      if (drain) hold_vld_d = 1'b0;
      if (trig) begin
         if (!hold_vld_q || drain) begin
            hold_d     = rx_data;
            hold_vld_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk_in) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         half_q     <= 1'b0;
         bit_q      <= '0;
         shift_q    <= '0;
         hold_q     <= '0;
         hold_vld_q <= 1'b0;
         flag_q     <= 1'b0;
         man_q      <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         ovr_q      <= 1'b0;
`ifdef PARITY_EN
         par_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         half_q     <= half_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         hold_q     <= hold_d;
         hold_vld_q <= hold_vld_d;
         flag_q     <= rx_flag;
         man_q      <= man_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         ovr_q      <= ovr_d;
`ifdef PARITY_EN
         par_q      <= par_d;
`endif
      end
   end

   assign man_out = man_q;
   assign tx_busy = busy_q;
   assign tx_done = done_q;
   assign overrun = ovr_q;

endmodule

// File: tb/tb_manchester_tx.sv
// Directed bench for manchester_tx. It builds the expected line waveform for
// each frame from the data word and checks it cycle by cycle. It also checks
// the busy/done handshake, the holding register, the overrun flag and reset.
module tb_manchester_tx;
   localparam int DATA_W    = 16;
   localparam int CLK_DIV   = 4;
   localparam int SYNC_BITS = 3;
`ifdef PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int FRAME = (SYNC_BITS + DATA_W + P + 1) * 2 * CLK_DIV;

   logic              clk_in = 1'b0;
   logic              rst = 1'b0;
   logic [DATA_W-1:0] rx_data = '0;
   logic              rx_flag = 1'b0;
   logic              man_out, tx_busy, tx_done, overrun;

   int checks = 0;
   int errors = 0;

   manchester_tx #(.DATA_W(DATA_W), .CLK_DIV(CLK_DIV), .SYNC_BITS(SYNC_BITS)) dut (
      .clk_in (clk_in),
      .rst    (rst),
      .rx_data(rx_data),
      .rx_flag(rx_flag),
      .man_out(man_out),
      .tx_busy(tx_busy),
      .tx_done(tx_done),
      .overrun(overrun)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   // Expected line level c cycles after the first half-bit starts.
   function automatic logic exp_man(int c, logic [DATA_W-1:0] w);
      int   b;
      logic h;
      logic v;
      b = c / (2 * CLK_DIV);
      h = ((c / CLK_DIV) % 2) == 1;
      if (b < SYNC_BITS)                         v = 1'b1;
      else if (b < SYNC_BITS + DATA_W)           v = w[DATA_W - 1 - (b - SYNC_BITS)];
      else if (P == 1 && b == SYNC_BITS + DATA_W) v = ^w;
      else                                       return 1'b0;
      return h ? v : ~v;
   endfunction

   // Call this right after the edge on which the holding register becomes
   // valid. Optional injections raise rx_flag with a new word at frame cycle c
   // and drop it three cycles later.
   task automatic frame(string tag, logic [DATA_W-1:0] w, bit keep_flag,
                        int i1c, logic [DATA_W-1:0] i1w,
                        int i2c, logic [DATA_W-1:0] i2w);
      if (!keep_flag) rx_flag = 1'b0;
      tick();
      chk({tag, " busy_at_load"}, tx_busy, 1);
      chk({tag, " line_at_load"}, man_out, 0);
      for (int c = 0; c < FRAME; c++) begin
         tick();
         chk($sformatf("%s man c=%0d", tag, c), man_out, exp_man(c, w));
         chk($sformatf("%s busy c=%0d", tag, c), tx_busy, (c < FRAME - 1) ? 1 : 0);
         chk($sformatf("%s done c=%0d", tag, c), tx_done, (c == FRAME - 1) ? 1 : 0);
         if (c == i1c) begin rx_data = i1w; rx_flag = 1'b1; end
         if (c == i2c) begin rx_data = i2w; rx_flag = 1'b1; end
         if ((i1c >= 0 && c == i1c + 3) || (i2c >= 0 && c == i2c + 3)) rx_flag = 1'b0;
      end
   endtask

   initial begin
      logic saw;

      // Reset state
      tick();
      tick();
      chk("rst man_out", man_out, 0);
      chk("rst tx_busy", tx_busy, 0);
      chk("rst tx_done", tx_done, 0);
      chk("rst overrun", overrun, 0);
      rst = 1'b1;
      tick();

      // Basic frame
      rx_data = 16'h00A5; rx_flag = 1'b1;
      tick();
      frame("basic", 16'h00A5, 0, -1, '0, -1, '0);
      tick();
      chk("basic done_single", tx_done, 0);
      chk("basic idle_busy", tx_busy, 0);

      // Level flag held high: one frame only
      rx_data = 16'hC3C3; rx_flag = 1'b1;
      tick();
      frame("level", 16'hC3C3, 1, -1, '0, -1, '0);
      saw = 1'b0;
      for (int i = 0; i < 500 - FRAME; i++) begin
         tick();
         saw = saw | tx_busy | tx_done;
      end
      chk("level no_second_frame", saw, 0);
      chk("level overrun", overrun, 0);
      rx_flag = 1'b0;
      tick();

      // Back-to-back: second word held, starts right after first tx_done
      rx_data = 16'h1234; rx_flag = 1'b1;
      tick();
      frame("b2b1", 16'h1234, 0, 40, 16'h5678, -1, '0);
      frame("b2b2", 16'h5678, 0, -1, '0, -1, '0);
      chk("b2b overrun", overrun, 0);
      repeat (5) tick();

      // Overrun: third word dropped while the second is held
      rx_data = 16'h1111; rx_flag = 1'b1;
      tick();
      frame("ovr1", 16'h1111, 0, 20, 16'h2222, 60, 16'h3333);
      chk("ovr flag_set", overrun, 1);
      frame("ovr2", 16'h2222, 0, -1, '0, -1, '0);
      repeat (20) tick();
      chk("ovr no_third_frame", tx_busy, 0);
      chk("ovr sticky", overrun, 1);

      // Reset mid-frame
      rx_data = 16'hFFFF; rx_flag = 1'b1;
      tick();
      rx_flag = 1'b0;
      repeat (54) tick();
      chk("rstmid line_high_before", man_out, 1);
      rst = 1'b0;
      tick();
      chk("rstmid man_out", man_out, 0);
      chk("rstmid tx_busy", tx_busy, 0);
      chk("rstmid tx_done", tx_done, 0);
      chk("rstmid overrun", overrun, 0);
      tick();
      rst = 1'b1;
      saw = 1'b0;
      for (int i = 0; i < 200; i++) begin
         tick();
         saw = saw | tx_busy | tx_done | man_out;
      end
      chk("rstmid aborted_quiet", saw, 0);
      rx_data = 16'hFFFF; rx_flag = 1'b1;
      tick();
      frame("fresh", 16'hFFFF, 0, -1, '0, -1, '0);
      repeat (3) tick();

      // Odd-weight word (parity bit 1 when enabled)
      rx_data = 16'h0007; rx_flag = 1'b1;
      tick();
      frame("w0007", 16'h0007, 0, -1, '0, -1, '0);
      repeat (3) tick();

      // All zeros
      rx_data = 16'h0000; rx_flag = 1'b1;
      tick();
      frame("w0000", 16'h0000, 0, -1, '0, -1, '0);
      repeat (3) tick();
      chk("final overrun", overrun, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
